// File: rtl/offset14_to_float32.sv
// offset14_to_float32: 14-bit offset-binary ADC code -> IEEE-754 float32 over a 3-stage valid/ready pipeline.
// Define OFFSET14_TO_FLOAT32_NORM_SCALE_EN to scale the output by 2^-13 (full scale maps to [-1.0, +1.0)).
module offset14_to_float32 #(
  parameter int OFFSET = 8192
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [13:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  localparam int DATA_W = 14;
  localparam logic signed [DATA_W:0] OFFSET_S = OFFSET[DATA_W:0];
`ifdef OFFSET14_TO_FLOAT32_NORM_SCALE_EN
  localparam logic [8:0] EXP_BIAS = 9'd127;
`else
  localparam logic [8:0] EXP_BIAS = 9'd140;
`endif

  // |d| always fits in DATA_W bits because d is bounded by +/-16383
  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W:0] d);
    return d[DATA_W] ? DATA_W'(-d) : d[DATA_W-1:0];
  endfunction

  function automatic logic [3:0] lzc14(input logic [DATA_W-1:0] v);
    logic [3:0] n;
    logic       hit;
    n   = 4'd0;
    hit = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + 4'd1;
    end
    return n;
  endfunction

  // nm[13] is the hidden bit; it is clear only when the magnitude was zero
  function automatic logic [31:0] pack(input logic sign, input logic [3:0] lz,
                                       input logic [DATA_W-1:0] nm, input logic zero);
    logic [8:0]  e9;
    logic [7:0]  e8;
    logic [31:0] f;
    e9 = EXP_BIAS - {5'd0, lz};
    e8 = (e9 > 9'd255) ? 8'hFF : e9[7:0];
    if (zero || !nm[DATA_W-1]) f = 32'h0000_0000;
    else                       f = {sign, e8, nm[DATA_W-2:0], 10'd0};
    return f;
  endfunction

  logic                     ce;
  logic signed [DATA_W:0]   d_s0;
  logic [3:0]               lz_s1;
  logic [DATA_W-1:0]        nm_s1;

  logic                     vld_p0, vld_p1, vld_p2;
  logic                     sign_p0, zero_p0;
  logic [DATA_W-1:0]        mag_p0;
  logic                     sign_p1, zero_p1;
  logic [3:0]               lz_p1;
  logic [DATA_W-1:0]        nm_p1;
  logic [31:0]              data_p2;

  assign ce            = m_axis_tready | ~vld_p2;
  assign s_axis_tready = ce;
  assign d_s0          = $signed({1'b0, s_axis_tdata}) - OFFSET_S;
  assign lz_s1         = lzc14(mag_p0);
  assign nm_s1         = mag_p0 << lz_s1;

  // Stage 1: offset removal, sign/magnitude split
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p0  <= 1'b0;
      sign_p0 <= 1'b0;
      zero_p0 <= 1'b0;
      mag_p0  <= '0;
    end else if (ce) begin
      vld_p0  <= s_axis_tvalid;
      sign_p0 <= d_s0[DATA_W];
      zero_p0 <= (d_s0 == '0);
      mag_p0  <= abs_mag(d_s0);
    end
  end

  // Stage 2: normalize
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      zero_p1 <= 1'b0;
      lz_p1   <= '0;
      nm_p1   <= '0;
    end else if (ce) begin
      vld_p1  <= vld_p0;
      sign_p1 <= sign_p0;
      zero_p1 <= zero_p0;
      lz_p1   <= lz_s1;
      nm_p1   <= nm_s1;
    end
  end

  // Stage 3: pack sign/exponent/fraction
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p2  <= 1'b0;
      data_p2 <= 32'h0000_0000;
    end else if (ce) begin
      vld_p2  <= vld_p1;
      data_p2 <= pack(sign_p1, lz_p1, nm_p1, zero_p1);
    end
  end

  assign m_axis_tvalid = vld_p2;
  assign m_axis_tdata  = data_p2;

endmodule

// File: tb/tb_offset14_to_float32.sv
// Self-checking bench for offset14_to_float32: scoreboard of reference floats against the DUT output stream.
// Also instantiates OFFSET=0 and OFFSET=16383 variants for the offset extremes.
module tb_offset14_to_float32;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [13:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  logic [13:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] z_data, f_data;
  logic        z_valid, f_valid, z_sready, f_sready;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 aclk = ~aclk;

  offset14_to_float32 #(.OFFSET(8192)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready)
  );

  offset14_to_float32 #(.OFFSET(0)) dut_off0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(x_data), .s_axis_tvalid(x_valid), .s_axis_tready(z_sready),
    .m_axis_tdata(z_data), .m_axis_tvalid(z_valid), .m_axis_tready(x_ready)
  );

  offset14_to_float32 #(.OFFSET(16383)) dut_offmax (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(x_data), .s_axis_tvalid(x_valid), .s_axis_tready(f_sready),
    .m_axis_tdata(f_data), .m_axis_tvalid(f_valid), .m_axis_tready(x_ready)
  );

  // Reference: exact real value, converted through the double encoding
  function automatic logic [31:0] ref_float(input int code, input int off);
    real         r;
    logic [63:0] b;
    int          e;
    r = real'(code - off);
`ifdef OFFSET14_TO_FLOAT32_NORM_SCALE_EN
    r = r / 8192.0;
`endif
    if (r == 0.0) return 32'h0000_0000;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    x_valid = 1'b0;
    x_data  = '0;
    x_ready = 1'b1;
    #2;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h, required valid=0 data=00000000", m_valid, m_data);
    end
    step();
    step();
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle[%0d]: m_valid=%b s_ready=%b, required 0/1", i, m_valid, s_ready);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] codes[5];
    logic [31:0] exps[5];
    logic [31:0] e;
    codes = '{14'd8192, 14'd8193, 14'd8191, 14'd16383, 14'd0};
`ifdef OFFSET14_TO_FLOAT32_NORM_SCALE_EN
    exps = '{32'h0000_0000, 32'h3900_0000, 32'hB900_0000, 32'h3F7F_F800, 32'hBF80_0000};
`else
    exps = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h45FF_F800, 32'hC600_0000};
`endif
    m_ready = 1'b1;
    for (int it = 0; it < 12; it++) begin
      s_valid = (it < 5);
      s_data  = (it < 5) ? codes[it] : 14'd0;
      @(negedge aclk);
      if (s_valid && s_ready) q.push_back(exps[it]);
      checks++;
      if (m_valid !== (it >= 3 && it < 8)) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: m_valid=%b, required %b", it, m_valid, (it >= 3 && it < 8));
      end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra[%0d]: output %h with no pending input", it, m_data);
        end else begin
          e = q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL b2b_data[%0d]: got %h, required %h", it, m_data, e);
          end
        end
      end
      step();
    end
    s_valid = 1'b0;
    q.delete();
  endtask

  task automatic test_sweep();
    int sent = 0;
    int got  = 0;
    int cyc;
    logic [31:0] e;
    m_ready = 1'b1;
    for (cyc = 0; cyc < 17000; cyc++) begin
      if (got == 16384) break;
      s_valid = (sent < 16384);
      s_data  = 14'(sent);
      @(negedge aclk);
      if (s_valid && s_ready) begin
        q.push_back(ref_float(sent, 8192));
        sent++;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sweep_extra: output %h with no pending input", m_data);
        end else begin
          e = q.pop_front();
          got++;
          if (m_data !== e) begin
            errors++;
            $display("FAIL sweep_data[%0d]: got %h, required %h", got - 1, m_data, e);
          end
        end
      end
      step();
    end
    s_valid = 1'b0;
    checks++;
    if (got != 16384 || cyc != 16384 + 3) begin
      errors++;
      $display("FAIL sweep_throughput: %0d outputs in %0d cycles, required 16384 in 16387", got, cyc);
    end
    q.delete();
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    int   got  = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] e;
    for (int cyc = 0; cyc < 20000 && got < 2000; cyc++) begin
      s_valid = (sent < 2000) && ($urandom_range(0, 1) == 1);
      s_data  = 14'($urandom_range(0, 16383));
      m_ready = ($urandom_range(0, 1) == 1);
      @(negedge aclk);
      checks++;
      if (s_ready !== (m_ready | ~m_valid)) begin
        errors++;
        $display("FAIL bp_sready[%0d]: s_ready=%b, required %b", cyc, s_ready, m_ready | ~m_valid);
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++;
          $display("FAIL bp_stable[%0d]: valid=%b data=%h, required 1/%h", cyc, m_valid, m_data, prev_data);
        end
      end
      if (s_valid && s_ready) begin
        q.push_back(ref_float(int'(s_data), 8192));
        sent++;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra[%0d]: output %h with no pending input", cyc, m_data);
        end else begin
          e = q.pop_front();
          got++;
          if (m_data !== e) begin
            errors++;
            $display("FAIL bp_data[%0d]: got %h, required %h", got - 1, m_data, e);
          end
        end
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (got != 2000 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout: %0d outputs, %0d pending, required 2000/0", got, q.size());
    end
    q.delete();
    repeat (4) step();
  endtask

  task automatic test_midstream_reset();
    logic [31:0] e8200;
`ifdef OFFSET14_TO_FLOAT32_NORM_SCALE_EN
    e8200 = 32'h3A80_0000;
`else
    e8200 = 32'h4100_0000;
`endif
    m_ready = 1'b1;
    for (int it = 0; it < 3; it++) begin
      s_valid = 1'b1;
      s_data  = 14'(100 + 3000 * it);
      step();
    end
    s_valid = 1'b0;
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'h0) begin
      errors++;
      $display("FAIL midreset_out: valid=%b data=%h, required valid=0 data=00000000", m_valid, m_data);
    end
    q.delete();
    step();
    step();
    aresetn = 1'b1;
    for (int it = 0; it < 8; it++) begin
      s_valid = (it == 0);
      s_data  = 14'd8200;
      @(negedge aclk);
      checks++;
      if (m_valid !== (it == 3)) begin
        errors++;
        $display("FAIL midreset_valid[%0d]: m_valid=%b, required %b", it, m_valid, (it == 3));
      end
      if (m_valid) begin
        checks++;
        if (m_data !== e8200) begin
          errors++;
          $display("FAIL midreset_data[%0d]: got %h, required %h", it, m_data, e8200);
        end
      end
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_offset_extremes();
    logic [13:0] codes[3];
    logic [31:0] ez[3];
    logic [31:0] ef[3];
    codes = '{14'd16383, 14'd0, 14'd8192};
`ifdef OFFSET14_TO_FLOAT32_NORM_SCALE_EN
    ez = '{32'h3FFF_FC00, 32'h0000_0000, 32'h3F80_0000};
    ef = '{32'h0000_0000, 32'hBFFF_FC00, 32'hBF7F_F800};
`else
    ez = '{32'h467F_FC00, 32'h0000_0000, 32'h4600_0000};
    ef = '{32'h0000_0000, 32'hC67F_FC00, 32'hC5FF_F800};
`endif
    for (int it = 0; it < 8; it++) begin
      x_valid = (it < 3);
      x_data  = (it < 3) ? codes[it] : 14'd0;
      @(negedge aclk);
      checks++;
      if (z_valid !== (it >= 3 && it < 6) || f_valid !== (it >= 3 && it < 6)) begin
        errors++;
        $display("FAIL ext_valid[%0d]: z=%b f=%b, required %b", it, z_valid, f_valid, (it >= 3 && it < 6));
      end
      if (it >= 3 && it < 6) begin
        checks++;
        if (z_data !== ez[it-3] || f_data !== ef[it-3]) begin
          errors++;
          $display("FAIL ext_data[%0d]: off0=%h offmax=%h, required %h %h", it - 3, z_data, f_data, ez[it-3], ef[it-3]);
        end
      end
      step();
    end
    x_valid = 1'b0;
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_sweep();
    test_backpressure();
    test_midstream_reset();
    test_offset_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
